// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction fetch front end: bus channel widths,
// PC increment and counter sizing.
package fetch_unit_pkg;

    localparam int IR_ADDR_W = 32;
    localparam int IR_DATA_W = 32;
    localparam int IALIGN    = 4;

    // Counters must hold the value fifo_depth itself, hence the extra bit.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// Instruction buffer: synchronous FIFO holding {inst, pc} pairs. The head is
// read from the entry registers, so there is no combinational path from the push data.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_push,
    input  logic [WIDTH-1:0]            i_push_data,
    input  logic                        i_pop,
    input  logic                        i_flush,
    output logic [cnt_width(DEPTH)-1:0] o_count,
    output logic                        o_not_empty,
    output logic [WIDTH-1:0]            o_head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] w_entries [DEPTH];
    logic             w_push;
    logic             w_pop;

    // Flush wins over both push and pop.
    assign w_pop  = i_pop && !i_flush && (r_count != '0);
    assign w_push = i_push && !i_flush && ((r_count != CW'(DEPTH)) || w_pop);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] r_data;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_data <= '0;
                end else if (w_push && (r_wr_ptr == AW'(gi))) begin
                    r_data <= i_push_data;
                end
            end
            assign w_entries[gi] = r_data;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    assign o_count     = r_count;
    assign o_not_empty = (r_count != '0);
    assign o_head      = w_entries[r_rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, issues credit-limited word reads,
// tags returning words with their PC and discards words from redirected paths.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                  pc_width   = IR_ADDR_W,
    parameter int                  inst_width = IR_DATA_W,
    parameter logic [pc_width-1:0] pc_init    = '0,
    parameter int                  fifo_depth = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  ir_addr_valid,
    input  logic                  ir_addr_ready,
    output logic [pc_width-1:0]   ir_addr,
    input  logic                  ir_data_valid,
    output logic                  ir_data_ready,
    input  logic [inst_width-1:0] ir_data,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [inst_width-1:0] inst,
    output logic [pc_width-1:0]   inst_pc,
    input  logic                  pc_load,
    input  logic [pc_width-1:0]   pc_target
);

    localparam int            CW      = cnt_width(fifo_depth);
    localparam int            EW      = inst_width + pc_width;
    localparam logic [CW:0]   DEPTH_C = (CW+1)'(fifo_depth);

    logic [pc_width-1:0] r_pc;
    logic [pc_width-1:0] r_resp_pc;
    logic [CW-1:0]       r_outstanding;
    logic [CW-1:0]       r_drop_cnt;
    logic [CW-1:0]       w_fifo_count;
    logic [CW:0]         w_in_use;
    logic [pc_width-1:0] w_target;
    logic                w_addr_hs;
    logic                w_data_hs;
    logic                w_keep;
    logic                w_pop;
    logic [EW-1:0]       w_head;

    assign w_target = pc_target & ~pc_width'(IALIGN - 1);
    assign w_in_use = {1'b0, r_outstanding} + {1'b0, w_fifo_count};

    // A request is only issued when a buffer slot is already reserved for its
    // response, which is why read data never has to be back-pressured.
    assign ir_addr_valid = !rst && !pc_load && (w_in_use < DEPTH_C);
    assign ir_addr       = r_pc;
    assign ir_data_ready = 1'b1;

    assign w_addr_hs = ir_addr_valid && ir_addr_ready;
    assign w_data_hs = ir_data_valid;
    assign w_keep    = w_data_hs && (r_drop_cnt == '0) && !pc_load;
    assign w_pop     = inst_valid && inst_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= pc_init;
            r_resp_pc     <= pc_init;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_outstanding <= r_outstanding + CW'(w_addr_hs) - CW'(w_data_hs);
            if (pc_load) begin
                // Everything still in flight after this edge belongs to the old path.
                r_pc       <= w_target;
                r_resp_pc  <= w_target;
                r_drop_cnt <= r_outstanding - CW'(w_data_hs);
            end else begin
                if (w_addr_hs) begin
                    r_pc <= r_pc + pc_width'(IALIGN);
                end
                if (w_data_hs) begin
                    if (r_drop_cnt != '0) begin
                        r_drop_cnt <= r_drop_cnt - CW'(1);
                    end else begin
                        r_resp_pc <= r_resp_pc + pc_width'(IALIGN);
                    end
                end
            end
        end
    end

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (fifo_depth)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_keep),
        .i_push_data ({ir_data, r_resp_pc}),
        .i_pop       (w_pop),
        .i_flush     (pc_load),
        .o_count     (w_fifo_count),
        .o_not_empty (inst_valid),
        .o_head      (w_head)
    );

    assign inst    = w_head[EW-1 -: inst_width];
    assign inst_pc = w_head[pc_width-1:0];

    a_credit_bound : assert property (@(posedge clk) disable iff (rst) w_in_use <= DEPTH_C);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: an epoch-tagged memory model and an
// expected-PC stream predict every request, delivered instruction and credit state.
module tb_fetch_unit;

    localparam int          PW      = 32;
    localparam int          IW      = 32;
    localparam int          DEPTH   = 2;
    localparam logic [31:0] PC_INIT = 32'h0;

    logic          clk = 1'b0;
    logic          rst;
    logic          ir_addr_valid;
    logic          ir_addr_ready;
    logic [PW-1:0] ir_addr;
    logic          ir_data_valid;
    logic          ir_data_ready;
    logic [IW-1:0] ir_data;
    logic          inst_valid;
    logic          inst_ready;
    logic [IW-1:0] inst;
    logic [PW-1:0] inst_pc;
    logic          pc_load;
    logic [PW-1:0] pc_target;

    fetch_unit #(
        .pc_width   (PW),
        .inst_width (IW),
        .pc_init    (PC_INIT),
        .fifo_depth (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ir_addr_valid (ir_addr_valid),
        .ir_addr_ready (ir_addr_ready),
        .ir_addr       (ir_addr),
        .ir_data_valid (ir_data_valid),
        .ir_data_ready (ir_data_ready),
        .ir_data       (ir_data),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .pc_load       (pc_load),
        .pc_target     (pc_target)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } req_t;

    req_t        mem_q[$];
    logic [31:0] popped[$];
    logic [31:0] issued[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          epoch    = 0;
    int          buffered = 0;
    int          lat_min  = 0;
    int          lat_max  = 0;
    logic [31:0] exp_req  = PC_INIT;
    logic [31:0] exp_inst = PC_INIT;
    logic [31:0] key      = 32'h0;
    bit          last_addr_valid;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] q_at(input logic [31:0] q[$], input int idx);
        return (idx < q.size()) ? q[idx] : 32'hDEAD_BEEF;
    endfunction

    // One clock cycle: drive at negedge, check and respond at negedge+1, update model after posedge.
    task automatic step(input bit ld, input logic [31:0] tgt, input bit a_rdy, input bit i_rdy);
        bit          addr_hs;
        bit          data_fire;
        bit          pop;
        logic [31:0] s_pc;
        req_t        e;
        @(negedge clk);
        pc_load       = ld;
        pc_target     = tgt;
        ir_addr_ready = a_rdy;
        inst_ready    = i_rdy;
        ir_data_valid = 1'b0;
        ir_data       = '0;
        #1;
        check_eq("addr_valid", ir_addr_valid, (!ld && (mem_q.size() + buffered < DEPTH)));
        check_eq("data_ready", ir_data_ready, 1);
        check_eq("inst_valid", inst_valid, (buffered > 0));
        if (buffered > 0) begin
            check_eq("inst_pc", inst_pc, exp_inst);
            check_eq("inst", inst, exp_inst ^ key);
        end
        s_pc            = inst_pc;
        last_addr_valid = ir_addr_valid;
        addr_hs         = ir_addr_valid && a_rdy;
        if (addr_hs) begin
            check_eq("ir_addr", ir_addr, exp_req);
            mem_q.push_back('{addr: ir_addr,
                              due: cyc + int'($urandom_range(lat_max, lat_min)),
                              epoch: epoch});
            issued.push_back(ir_addr);
            exp_req += 32'd4;
        end
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            ir_data_valid = 1'b1;
            ir_data       = mem_q[0].addr ^ key;
        end
        data_fire = ir_data_valid;
        pop       = (buffered > 0) && i_rdy;
        @(posedge clk);
        cyc++;
        if (data_fire) begin
            e = mem_q.pop_front();
            if (!ld && e.epoch == epoch) buffered++;
        end
        if (ld) begin
            buffered = 0;
            epoch++;
            exp_req  = tgt & ~32'h3;
            exp_inst = tgt & ~32'h3;
        end else if (pop) begin
            popped.push_back(s_pc);
            buffered--;
            exp_inst += 32'd4;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b1;
        pc_load       = 1'b0;
        pc_target     = '0;
        ir_addr_ready = 1'b0;
        ir_data_valid = 1'b0;
        ir_data       = '0;
        inst_ready    = 1'b0;
        @(negedge clk);
        #1;
        check_eq("rst_addr_valid", ir_addr_valid, 0);
        check_eq("rst_inst_valid", inst_valid, 0);
        check_eq("rst_inst", inst, 0);
        check_eq("rst_inst_pc", inst_pc, 0);
        check_eq("rst_ir_addr", ir_addr, PC_INIT);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("post_rst_inst_valid", inst_valid, 0);
        check_eq("post_rst_ir_addr", ir_addr, PC_INIT);
        check_eq("post_rst_data_ready", ir_data_ready, 1);
        mem_q.delete();
        popped.delete();
        issued.delete();
        buffered = 0;
        epoch++;
        exp_req  = PC_INIT;
        exp_inst = PC_INIT;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; pc_load = 1'b0; pc_target = '0; ir_addr_ready = 1'b0;
        ir_data_valid = 1'b0; ir_data = '0; inst_ready = 1'b0;

        // Zero-wait memory, decoder always ready: one instruction per cycle.
        key = 32'h0; lat_min = 0; lat_max = 0;
        do_reset();
        for (int i = 0; i < 20; i++) step(0, 0, 1, 1);
        check_eq("t1_count", popped.size(), 19);
        check_eq("t1_first", q_at(popped, 0), 32'h0);
        check_eq("t1_pc5", q_at(popped, 5), 32'd20);

        // Decoder stalled: exactly DEPTH requests, then release with no gap.
        do_reset();
        for (int i = 0; i < 10; i++) step(0, 0, 1, 0);
        check_eq("t2_issued", issued.size(), DEPTH);
        check_eq("t2_valid_low", last_addr_valid, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1);
        check_eq("t2_pops", popped.size(), 3);
        check_eq("t2_pc0", q_at(popped, 0), 32'h0);
        check_eq("t2_pc1", q_at(popped, 1), 32'h4);
        check_eq("t2_pc2", q_at(popped, 2), 32'h8);

        // Redirect with two requests in flight on a 3-cycle memory.
        do_reset();
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 10 && mem_q.size() < 2; i++) step(0, 0, 1, 1);
        check_eq("t3_in_flight", mem_q.size(), 2);
        step(1, 32'h100, 1, 1);
        popped.delete(); issued.delete();
        for (int i = 0; i < 15; i++) step(0, 0, 1, 1);
        check_eq("t3_issue0", q_at(issued, 0), 32'h100);
        check_eq("t3_pc0", q_at(popped, 0), 32'h100);
        check_eq("t3_pc1", q_at(popped, 1), 32'h104);

        // Misaligned redirect target while memory is ready.
        do_reset();
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1);
        step(1, 32'h203, 1, 1);
        popped.delete(); issued.delete();
        for (int i = 0; i < 8; i++) step(0, 0, 1, 1);
        check_eq("t4_issue0", q_at(issued, 0), 32'h200);
        check_eq("t4_pc0", q_at(popped, 0), 32'h200);

        // PC wrap at the top of the address space.
        do_reset();
        lat_min = 0; lat_max = 0;
        step(1, 32'hFFFF_FFFC, 1, 1);
        popped.delete(); issued.delete();
        for (int i = 0; i < 5; i++) step(0, 0, 1, 1);
        check_eq("t5_issue0", q_at(issued, 0), 32'hFFFF_FFFC);
        check_eq("t5_issue1", q_at(issued, 1), 32'h0);
        check_eq("t5_pc0", q_at(popped, 0), 32'hFFFF_FFFC);
        check_eq("t5_pc1", q_at(popped, 1), 32'h0);

        // Reset while requests and buffered words are pending.
        do_reset();
        lat_min = 2; lat_max = 2;
        for (int i = 0; i < 6; i++) step(0, 0, 1, 0);
        check_eq("t6_issued", issued.size(), DEPTH);
        do_reset();
        step(0, 0, 1, 1);
        check_eq("t6_issue0", q_at(issued, 0), PC_INIT);

        // Randomized traffic: variable latency, back-pressure and redirects.
        do_reset();
        key = $urandom; lat_min = 0; lat_max = 3;
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 16) == 0, $urandom, ($urandom % 4) != 0, ($urandom % 10) < 7);
        end
        check_eq("rand_progress", (popped.size() > 200), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
